// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver with a synchronised input,
// start-bit glitch rejection, parity/framing/break detection and a
// valid/ready output holding register that reports dropped words.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | line idle, waiting for a low level on rx_s
//   S_START | counting to mid start bit to confirm a real start
//   S_DATA  | sampling D_BIT data bits at mid-bit, LSB first
//   S_PAR   | sampling the parity bit (only when PARITY != 0)
//   S_STOP  | sampling STOP_BITS stop bits, then completing the frame
//   S_BRK   | line held low after a break/framing error, wait for high
module uart_rx_frame #(
    parameter int D_BIT     = 8,
    parameter int OS        = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx,
    input  logic             s_tick,
    output logic [D_BIT-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             break_det
);

    localparam int SW = $clog2(OS);
    localparam int NW = $clog2(D_BIT);

    localparam logic [SW-1:0] S_HALF = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_FULL = SW'(OS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(D_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BRK
    } state_t;

    logic [1:0]       sync_q;
    logic             rx_s;

    state_t           state_q;
    logic [SW-1:0]    s_cnt_q;
    logic [NW-1:0]    n_cnt_q;
    logic             stop_cnt_q;
    logic [D_BIT-1:0] shreg_q;
    logic             par_q;
    logic             ferr_q;
    logic             stop_one_q;

    logic [D_BIT-1:0] dout_q;
    logic             dout_valid_q;
    logic             parity_err_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             break_q;

    logic             mid_d;
    logic             perr_d;
    logic             ferr_d;
    logic             stop_one_d;
    logic             is_brk_d;
    logic             can_load_d;

    assign rx_s = sync_q[1];

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Sample-point and frame-completion decisions derived from current state.
    always_comb begin
        mid_d      = (s_cnt_q == S_FULL);
        perr_d     = 1'b0;
        if (PARITY == 1) begin
            perr_d = (^shreg_q) ^ par_q;
        end else if (PARITY == 2) begin
            perr_d = ~((^shreg_q) ^ par_q);
        end
        // Fold in the stop sample being taken this tick so completion sees it.
        ferr_d     = ferr_q | ~rx_s;
        stop_one_d = stop_one_q | rx_s;
        is_brk_d   = (shreg_q == '0) && ((PARITY == 0) || !par_q) && !stop_one_d;
        can_load_d = !dout_valid_q || dout_ready;
    end

    // Receive FSM plus the registered output word and status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            s_cnt_q      <= '0;
            n_cnt_q      <= '0;
            stop_cnt_q   <= 1'b0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            ferr_q       <= 1'b0;
            stop_one_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            break_q   <= 1'b0;
            // Handshake runs every clk; a load below overrides this clear.
            if (dout_valid_q && dout_ready) begin
                dout_valid_q <= 1'b0;
            end
            if (s_tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (!rx_s) begin
                            s_cnt_q <= '0;
                            state_q <= S_START;
                        end
                    end
                    S_START: begin
                        if (s_cnt_q == S_HALF) begin
                            if (rx_s) begin
                                state_q <= S_IDLE;
                            end else begin
                                s_cnt_q <= '0;
                                n_cnt_q <= '0;
                                state_q <= S_DATA;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (mid_d) begin
                            s_cnt_q <= '0;
                            shreg_q <= {rx_s, shreg_q[D_BIT-1:1]};
                            if (n_cnt_q == N_LAST) begin
                                stop_cnt_q <= 1'b0;
                                ferr_q     <= 1'b0;
                                stop_one_q <= 1'b0;
                                par_q      <= 1'b0;
                                state_q    <= (PARITY != 0) ? S_PAR : S_STOP;
                            end else begin
                                n_cnt_q <= n_cnt_q + 1'b1;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                    S_PAR: begin
                        if (mid_d) begin
                            s_cnt_q <= '0;
                            par_q   <= rx_s;
                            state_q <= S_STOP;
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (mid_d) begin
                            s_cnt_q    <= '0;
                            ferr_q     <= ferr_d;
                            stop_one_q <= stop_one_d;
                            if (stop_cnt_q == STOP_LAST) begin
                                if (is_brk_d) begin
                                    break_q <= 1'b1;
                                    state_q <= S_BRK;
                                end else begin
                                    if (can_load_d) begin
                                        dout_q       <= shreg_q;
                                        parity_err_q <= perr_d;
                                        frame_err_q  <= ferr_d;
                                        dout_valid_q <= 1'b1;
                                    end else begin
                                        overrun_q <= 1'b1;
                                    end
                                    // A bad stop bit may mean the line is still low.
                                    state_q <= ferr_d ? S_BRK : S_IDLE;
                                end
                            end else begin
                                stop_cnt_q <= 1'b1;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + 1'b1;
                        end
                    end
                    S_BRK: begin
                        if (rx_s) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;
    assign break_det   = break_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames into four receiver configurations
// (8N1, 8E1, 8O1, 7N2) with hand-computed expected words and status.
module tb_uart_rx_frame;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic       s_tick;
    logic [3:0] rx;
    logic [3:0] rdy;
    logic [7:0] dout0, dout1, dout2;
    logic [6:0] dout3;
    logic [3:0] vld, perr, ferr, ovr, brk;

    int total = 0;
    int bad   = 0;
    int ovr_cnt0 = 0;
    int brk_cnt0 = 0;

    always #5 clk = ~clk;

    uart_rx_frame #(.D_BIT(8), .OS(16), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(rst_a), .rx(rx[0]), .s_tick(s_tick),
        .dout(dout0), .dout_valid(vld[0]), .dout_ready(rdy[0]),
        .parity_err(perr[0]), .frame_err(ferr[0]),
        .overrun_err(ovr[0]), .break_det(brk[0]));

    uart_rx_frame #(.D_BIT(8), .OS(16), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(rst_a), .rx(rx[1]), .s_tick(s_tick),
        .dout(dout1), .dout_valid(vld[1]), .dout_ready(rdy[1]),
        .parity_err(perr[1]), .frame_err(ferr[1]),
        .overrun_err(ovr[1]), .break_det(brk[1]));

    uart_rx_frame #(.D_BIT(8), .OS(16), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(rst_a), .rx(rx[2]), .s_tick(s_tick),
        .dout(dout2), .dout_valid(vld[2]), .dout_ready(rdy[2]),
        .parity_err(perr[2]), .frame_err(ferr[2]),
        .overrun_err(ovr[2]), .break_det(brk[2]));

    uart_rx_frame #(.D_BIT(7), .OS(16), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(rst_b), .rx(rx[3]), .s_tick(s_tick),
        .dout(dout3), .dout_valid(vld[3]), .dout_ready(rdy[3]),
        .parity_err(perr[3]), .frame_err(ferr[3]),
        .overrun_err(ovr[3]), .break_det(brk[3]));

    // Pulse counters for the 8N1 instance, sampled away from the active edge.
    always @(negedge clk) begin
        if (ovr[0]) ovr_cnt0 <= ovr_cnt0 + 1;
        if (brk[0]) brk_cnt0 <= brk_cnt0 + 1;
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One s_tick lasting one clk, optionally with dout_ready in that same cycle.
    task automatic tick(input int sel, input bit r);
        @(negedge clk);
        s_tick = 1'b1;
        if (r) rdy[sel] = 1'b1;
        @(negedge clk);
        s_tick   = 1'b0;
        rdy[sel] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) tick(0, 1'b0);
    endtask

    // Start bit, nb bits from bits[] (LSB first), then one idle bit time.
    // The line fall is seen on tick 2, so bit k (k>=1 after start) is
    // sampled on tick 10+16*k; rdy_at names the tick that carries dout_ready.
    task automatic send(input int sel, input logic [15:0] bits, input int nb, input int rdy_at);
        int t = 0;
        rx[sel] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            t++;
            tick(sel, t == rdy_at);
        end
        for (int i = 0; i < nb; i++) begin
            rx[sel] = bits[i];
            for (int k = 0; k < 16; k++) begin
                t++;
                tick(sel, t == rdy_at);
            end
        end
        rx[sel] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            t++;
            tick(sel, t == rdy_at);
        end
    endtask

    task automatic take(input int sel);
        @(negedge clk);
        rdy[sel] = 1'b1;
        @(negedge clk);
        rdy[sel] = 1'b0;
    endtask

    initial begin
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        rx     = 4'hF;
        rdy    = 4'h0;
        s_tick = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_dout",  16'(dout0),   16'h0);
        check_val("rst_valid", 16'(vld),     16'h0);
        check_val("rst_perr",  16'(perr),    16'h0);
        check_val("rst_ferr",  16'(ferr),    16'h0);
        check_val("rst_ovr",   16'(ovr),     16'h0);
        check_val("rst_brk",   16'(brk),     16'h0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        ticks(4);

        // 8N1 0x55, held until taken
        send(0, {7'h0, 1'b1, 8'h55}, 9, 0);
        ticks(8);
        check_val("n1_dout",  16'(dout0),   16'h55);
        check_val("n1_valid", 16'(vld[0]),  16'h1);
        check_val("n1_perr",  16'(perr[0]), 16'h0);
        check_val("n1_ferr",  16'(ferr[0]), 16'h0);
        take(0);
        check_val("n1_taken", 16'(vld[0]),  16'h0);

        // 0xA3 has four ones: even parity bit should be 0, odd parity bit 1
        send(1, {6'h0, 1'b1, 1'b1, 8'hA3}, 10, 0);
        check_val("ev_bad_dout", 16'(dout1),   16'hA3);
        check_val("ev_bad_perr", 16'(perr[1]), 16'h1);
        take(1);
        send(1, {6'h0, 1'b1, 1'b0, 8'hA3}, 10, 0);
        check_val("ev_ok_perr",  16'(perr[1]), 16'h0);
        check_val("ev_ok_valid", 16'(vld[1]),  16'h1);
        send(2, {6'h0, 1'b1, 1'b1, 8'hA3}, 10, 0);
        check_val("od_dout", 16'(dout2),   16'hA3);
        check_val("od_perr", 16'(perr[2]), 16'h0);

        // Start glitch of 4 ticks is rejected, next frame still lands
        rx[0] = 1'b0;
        ticks(4);
        rx[0] = 1'b1;
        ticks(20);
        check_val("gl_valid", 16'(vld[0]), 16'h0);
        send(0, {7'h0, 1'b1, 8'h3C}, 9, 0);
        check_val("gl_dout",  16'(dout0),  16'h3C);
        check_val("gl_valid2", 16'(vld[0]), 16'h1);
        take(0);

        // Overrun, then ready exactly in the completion cycle (tick 10+16*9)
        send(0, {7'h0, 1'b1, 8'h11}, 9, 0);
        send(0, {7'h0, 1'b1, 8'h22}, 9, 0);
        check_val("ov_cnt",  16'(ovr_cnt0), 16'd1);
        check_val("ov_dout", 16'(dout0),    16'h11);
        check_val("ov_valid", 16'(vld[0]),  16'h1);
        send(0, {7'h0, 1'b1, 8'h33}, 9, 154);
        check_val("rc_cnt",   16'(ovr_cnt0), 16'd1);
        check_val("rc_dout",  16'(dout0),    16'h33);
        check_val("rc_valid", 16'(vld[0]),   16'h1);
        take(0);

        // Break: 12 bit times low, then stay low longer without retrigger
        rx[0] = 1'b0;
        ticks(192);
        check_val("br_cnt",   16'(brk_cnt0), 16'd1);
        check_val("br_valid", 16'(vld[0]),   16'h0);
        ticks(48);
        check_val("br_hold",  16'(brk_cnt0), 16'd1);
        check_val("br_hold_valid", 16'(vld[0]), 16'h0);
        rx[0] = 1'b1;
        ticks(16);

        // Stop bit 0 with nonzero data is a framing error, not a break
        send(0, {7'h0, 1'b0, 8'h80}, 9, 0);
        check_val("fe_dout",  16'(dout0),    16'h80);
        check_val("fe_ferr",  16'(ferr[0]),  16'h1);
        check_val("fe_perr",  16'(perr[0]),  16'h0);
        check_val("fe_brk",   16'(brk_cnt0), 16'd1);
        take(0);

        // 7N2: second stop bit low
        send(3, {7'h0, 1'b0, 1'b1, 7'h5A}, 9, 0);
        check_val("s2_dout",  16'(dout3),   16'h5A);
        check_val("s2_ferr",  16'(ferr[3]), 16'h1);
        check_val("s2_valid", 16'(vld[3]),  16'h1);

        // Reset mid-DATA clears everything at once
        rx[3] = 1'b0;
        for (int k = 0; k < 56; k++) tick(3, 1'b0);
        rx[3] = 1'b1;
        for (int k = 0; k < 8; k++) tick(3, 1'b0);
        rst_b = 1'b1;
        #1;
        check_val("mr_dout",  16'(dout3),   16'h0);
        check_val("mr_valid", 16'(vld[3]),  16'h0);
        check_val("mr_ferr",  16'(ferr[3]), 16'h0);
        check_val("mr_perr",  16'(perr[3]), 16'h0);
        @(negedge clk);
        rst_b = 1'b0;
        ticks(4);
        send(3, {7'h0, 1'b1, 1'b1, 7'h2B}, 9, 0);
        check_val("ar_dout",  16'(dout3),   16'h2B);
        check_val("ar_valid", 16'(vld[3]),  16'h1);
        check_val("ar_ferr",  16'(ferr[3]), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
